// File: rtl/regfile_wb_queue_if.sv
// Writeback-queue bus: pipeline write requests, one-hot drain strobe to the
// register array, and the two decode-stage lookup ports.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_reg;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic [15:0]   WriteReg;
    logic [DW-1:0] D;
    logic [3:0]    rd_reg1;
    logic          rd_hit1;
    logic [DW-1:0] rd_data1;
    logic [3:0]    rd_reg2;
    logic          rd_hit2;
    logic [DW-1:0] rd_data2;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output in_valid, in_reg, in_data, drain_en, rd_reg1, rd_reg2,
        input  in_ready, WriteReg, D, rd_hit1, rd_data1, rd_hit2, rd_data2, count, empty
    );

    modport slave (
        input  in_valid, in_reg, in_data, drain_en, rd_reg1, rd_reg2,
        output in_ready, WriteReg, D, rd_hit1, rd_data1, rd_hit2, rd_data2, count, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO draining one entry per cycle into a one-hot register strobe.
// Define REGFILE_WB_BYPASS_EN to build the youngest-pending-value lookup ports.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [DEPTH-1:0] r_valid;
    logic [3:0]    r_q_reg  [DEPTH];
    logic [DW-1:0] r_q_data [DEPTH];
    logic [15:0]   r_write_reg;
    logic [DW-1:0] r_d;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Writes to R0 are swallowed here so they never occupy a slot.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = bus.in_valid && !w_full && (bus.in_reg != 4'd0);
    assign w_pop  = bus.drain_en && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_valid     <= '0;
            r_write_reg <= '0;
            r_d         <= '0;
        end else begin
            if (w_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
                r_write_reg     <= 16'(1) << r_q_reg[r_head];
                r_d             <= r_q_data[r_head];
            end else begin
                r_write_reg <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_reg[r_tail]  <= bus.in_reg;
            r_q_data[r_tail] <= bus.in_data;
        end
    end

    assign bus.in_ready = !w_full;
    assign bus.WriteReg = r_write_reg;
    assign bus.D        = r_d;
    assign bus.count    = r_count;
    assign bus.empty    = (r_count == '0) && (r_write_reg == '0);

`ifdef REGFILE_WB_BYPASS_EN
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic [3:0]    w_sel;
            logic          w_hit;
            logic [DW-1:0] w_data;

            assign w_sel = (gi == 0) ? bus.rd_reg1 : bus.rd_reg2;

            // Scan oldest to youngest so the last match left standing wins.
            always_comb begin
                w_hit  = 1'b0;
                w_data = '0;
                if (w_sel != 4'd0) begin
                    if (r_write_reg[w_sel]) begin
                        w_hit  = 1'b1;
                        w_data = r_d;
                    end
                    for (int i = 0; i < DEPTH; i++) begin
                        if (r_valid[r_head + PW'(i)] && (r_q_reg[r_head + PW'(i)] == w_sel)) begin
                            w_hit  = 1'b1;
                            w_data = r_q_data[r_head + PW'(i)];
                        end
                    end
                end
            end
        end
    endgenerate

    assign bus.rd_hit1  = g_lookup[0].w_hit;
    assign bus.rd_data1 = g_lookup[0].w_data;
    assign bus.rd_hit2  = g_lookup[1].w_hit;
    assign bus.rd_data2 = g_lookup[1].w_data;
`else
    logic w_unused_rd;
    assign w_unused_rd  = ^{bus.rd_reg1, bus.rd_reg2};
    assign bus.rd_hit1  = 1'b0;
    assign bus.rd_data1 = '0;
    assign bus.rd_hit2  = 1'b0;
    assign bus.rd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboarded bench for regfile_wb_queue: accepted writes are queued as
// expected strobes and matched against every WriteReg pulse.
module tb_regfile_wb_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DEPTH(4), .DW(16)) bus ();

    regfile_wb_queue #(.DEPTH(4), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Every strobe must match the oldest outstanding accepted write.
    always @(negedge clk) begin
        if (rst && bus.WriteReg != 16'h0000) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected WriteReg=%h D=%h required no pulse", bus.WriteReg, bus.D);
            end else begin
                exp_t e;
                logic [15:0] one;
                e   = sb.pop_front();
                one = 16'h0001 << e.r;
                if (bus.WriteReg !== one || bus.D !== e.d) begin
                    failures++;
                    $display("FAIL drain_order WriteReg=%h D=%h required WriteReg=%h D=%h", bus.WriteReg, bus.D, one, e.d);
                end else begin
                    $display("drain R%0d <= %h", e.r, e.d);
                end
            end
        end
    end

    task automatic send(input logic [3:0] r, input logic [15:0] d);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%b required 1 within 50 cycles", bus.in_ready);
        end else begin
            if (r != 4'd0) sb.push_back('{r, d});
            $display("send R%0d <= %h", r, d);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || bus.WriteReg != 16'h0000 || bus.count != 3'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL idle_timeout pending=%0d count=%0d empty=%b required 0/0/1", sb.size(), bus.count, bus.empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_reg = 4'd0; bus.in_data = 16'h0;
        bus.drain_en = 1'b0; bus.rd_reg1 = 4'd0; bus.rd_reg2 = 4'd0;
        #1 rst = 1'b0;
        #2;
        checks++;
        if (bus.WriteReg !== 16'h0 || bus.D !== 16'h0 || bus.count !== 3'd0 ||
            bus.empty !== 1'b1 || bus.in_ready !== 1'b1 || bus.rd_hit1 !== 1'b0 || bus.rd_hit2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state WriteReg=%h D=%h count=%0d empty=%b in_ready=%b required 0000/0000/0/1/1",
                     bus.WriteReg, bus.D, bus.count, bus.empty, bus.in_ready);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.drain_en = 1'b1;
        send(4'd5, 16'hBEEF);
        checks++;
        if (bus.count !== 3'd1 || bus.WriteReg !== 16'h0) begin
            failures++;
            $display("FAIL single_accept count=%0d WriteReg=%h required 1/0000", bus.count, bus.WriteReg);
        end
        @(negedge clk);
        checks++;
        if (bus.WriteReg !== 16'h0020 || bus.D !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_latency WriteReg=%h D=%h required 0020/BEEF", bus.WriteReg, bus.D);
        end
        @(negedge clk);
        checks++;
        if (bus.WriteReg !== 16'h0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL single_pulse WriteReg=%h empty=%b required 0000/1", bus.WriteReg, bus.empty);
        end
    endtask

    task automatic test_full();
        bus.drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'(i), 16'h1000 + 16'(i));
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_flag count=%0d in_ready=%b required 4/0", bus.count, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_reg = 4'd6; bus.in_data = 16'h0006;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_hold count=%0d in_ready=%b required 4/0", bus.count, bus.in_ready);
        end
        bus.drain_en = 1'b1;
        send(4'd6, 16'h0006);
        wait_idle();
    endtask

    task automatic test_r0_drop();
        bus.drain_en = 1'b1;
        send(4'd0, 16'h1234);
        checks++;
        if (bus.count !== 3'd0) begin
            failures++;
            $display("FAIL r0_count count=%0d required 0", bus.count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.WriteReg !== 16'h0) begin
            failures++;
            $display("FAIL r0_empty empty=%b WriteReg=%h required 1/0000", bus.empty, bus.WriteReg);
        end
    endtask

    task automatic test_bypass();
`ifdef REGFILE_WB_BYPASS_EN
        bus.drain_en = 1'b0;
        send(4'd3, 16'h0001);
        send(4'd4, 16'h0044);
        send(4'd3, 16'h0002);
        bus.rd_reg1 = 4'd3; bus.rd_reg2 = 4'd4;
        #1;
        checks++;
        if (bus.rd_hit1 !== 1'b1 || bus.rd_data1 !== 16'h0002 || bus.rd_hit2 !== 1'b1 || bus.rd_data2 !== 16'h0044) begin
            failures++;
            $display("FAIL bypass_queued hit1=%b data1=%h hit2=%b data2=%h required 1/0002/1/0044",
                     bus.rd_hit1, bus.rd_data1, bus.rd_hit2, bus.rd_data2);
        end
        bus.drain_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rd_hit2 !== 1'b1 || bus.rd_data2 !== 16'h0044 || bus.rd_data1 !== 16'h0002) begin
            failures++;
            $display("FAIL bypass_outreg hit2=%b data2=%h data1=%h required 1/0044/0002", bus.rd_hit2, bus.rd_data2, bus.rd_data1);
        end
        @(negedge clk);
        checks++;
        if (bus.rd_hit1 !== 1'b1 || bus.rd_data1 !== 16'h0002 || bus.rd_hit2 !== 1'b0 || bus.rd_data2 !== 16'h0) begin
            failures++;
            $display("FAIL bypass_last hit1=%b data1=%h hit2=%b data2=%h required 1/0002/0/0000",
                     bus.rd_hit1, bus.rd_data1, bus.rd_hit2, bus.rd_data2);
        end
        wait_idle();
        checks++;
        if (bus.rd_hit1 !== 1'b0 || bus.rd_data1 !== 16'h0) begin
            failures++;
            $display("FAIL bypass_drained hit1=%b data1=%h required 0/0000", bus.rd_hit1, bus.rd_data1);
        end
`else
        bus.drain_en = 1'b0;
        send(4'd3, 16'h0001);
        bus.rd_reg1 = 4'd3;
        #1;
        checks++;
        if (bus.rd_hit1 !== 1'b0 || bus.rd_data1 !== 16'h0) begin
            failures++;
            $display("FAIL nobypass_tied hit1=%b data1=%h required 0/0000", bus.rd_hit1, bus.rd_data1);
        end
        bus.drain_en = 1'b1;
        wait_idle();
`endif
        bus.rd_reg1 = 4'd0; bus.rd_reg2 = 4'd0;
    endtask

    task automatic test_back_to_back();
        bus.drain_en = 1'b0;
        send(4'd9, 16'h0909);
        send(4'd10, 16'h0A0A);
        checks++;
        if (bus.count !== 3'd2) begin
            failures++;
            $display("FAIL b2b_prefill count=%0d required 2", bus.count);
        end
        for (int k = 0; k < 8; k++) begin
            bus.drain_en = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_reg   = 4'(k + 1);
            bus.in_data  = 16'hA000 + 16'(k);
            sb.push_back('{4'(k + 1), 16'hA000 + 16'(k)});
            $display("send R%0d <= %h", k + 1, 16'hA000 + 16'(k));
            @(negedge clk);
            checks++;
            if (bus.count !== 3'd2) begin
                failures++;
                $display("FAIL b2b_count cycle=%0d count=%0d required 2", k, bus.count);
            end
        end
        bus.in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid_burst();
        bus.drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'(i), 16'h00C0 + 16'(i));
        bus.drain_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== 3'd3 || bus.WriteReg !== 16'h0002) begin
            failures++;
            $display("FAIL midrst_pre count=%0d WriteReg=%h required 3/0002", bus.count, bus.WriteReg);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.WriteReg !== 16'h0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async WriteReg=%h count=%0d empty=%b in_ready=%b required 0000/0/1/1",
                     bus.WriteReg, bus.count, bus.empty, bus.in_ready);
        end
        sb.delete();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after count=%0d empty=%b required 0/1", bus.count, bus.empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_r0_drop();
        test_bypass();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
